// File: rtl/cpuregs_pkg.sv
// Shared types and constants for the register-file port sequencer.
package cpuregs_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD1,
        ST_RD2,
        ST_CAP2,
        ST_RSP
    } cpuregs_seq_state_t;

    localparam int CPUREGS_DEPTH     = 64;
    localparam int CPUREGS_ZERO_ADDR = 0;

endpackage

// File: rtl/cpuregs_fwd_slot.sv
// One operand's write-forward slot: it catches writes to the latched address while a read is in flight.
// The flag and data are registered, and this block never stalls; the last matching write wins.
module cpuregs_fwd_slot #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              win_i,
    input  logic              wen_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic              fwd_vld_o,
    output logic [DATA_W-1:0] fwd_dat_o
);

    logic              fwd_vld_q, fwd_vld_d;
    logic [DATA_W-1:0] fwd_dat_q, fwd_dat_d;
    logic              hit;

    assign hit = win_i & wen_i & (waddr_i == addr_i);

    always_comb begin
        fwd_vld_d = fwd_vld_q;
        fwd_dat_d = fwd_dat_q;
        if (clr_i) begin
            fwd_vld_d = 1'b0;
        end else if (hit) begin
            fwd_vld_d = 1'b1;
            fwd_dat_d = wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_vld_q <= 1'b0;
            fwd_dat_q <= '0;
        end else begin
            fwd_vld_q <= fwd_vld_d;
            fwd_dat_q <= fwd_dat_d;
        end
    end

    assign fwd_vld_o = fwd_vld_q;
    assign fwd_dat_o = fwd_dat_q;

endmodule

// File: rtl/cpuregs_port_sequencer.sv
// Serializes the rs1/rs2 reads onto the single BRAM read port, with x0 suppression, write forwarding and an optional zero-fill.
// An accepted request gives rsp_valid 3 cycles after acceptance, and the response is held until rsp_ready; req_ready is high only in IDLE.
module cpuregs_port_sequencer
    import cpuregs_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter int DATA_W         = 32,
    parameter bit ZERO_REG       = 1'b1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata1,
    output logic [DATA_W-1:0] rsp_rdata2,
    input  logic              wen,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic              init_busy,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dia,
    output logic [ADDR_W-1:0] ram_addrb,
    input  logic [DATA_W-1:0] ram_dob,
    output logic              ram_rsta,
    output logic              ram_rstb
);

    localparam cpuregs_seq_state_t RESET_STATE = CLEAR_ON_RESET ? ST_INIT : ST_IDLE;
    localparam logic [ADDR_W-1:0]  ZERO_ADDR   = ADDR_W'(CPUREGS_ZERO_ADDR);
    localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(CPUREGS_DEPTH - 1);

    cpuregs_seq_state_t state_q, state_d;
    logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
    logic [ADDR_W-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0]  op1_q, op1_d, op2_q, op2_d;
    logic               req_ready_q;
    logic               in_init, accept, wr_acc;
    logic               fwd1_vld, fwd2_vld;
    logic [DATA_W-1:0]  fwd1_dat, fwd2_dat;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == ZERO_ADDR);
    endfunction

    assign in_init   = (state_q == ST_INIT);
    assign init_busy = in_init;
    assign accept    = (state_q == ST_IDLE) & req_valid & req_ready_q;
    assign wr_acc    = wen & ~rst & ~in_init & ~is_zero(waddr);

    assign ram_cea   = in_init ? ~rst : wr_acc;
    assign ram_addra = in_init ? init_cnt_q : waddr;
    assign ram_dia   = in_init ? '0 : wdata;
    assign ram_rsta  = 1'b0;
    assign ram_rstb  = 1'b0;

    assign req_ready = req_ready_q;
    assign rsp_valid = (state_q == ST_RSP);

    always_comb begin
        ram_addrb = '0;
        case (state_q)
            ST_RD1:  ram_addrb = rs1_q;
            ST_RD2:  ram_addrb = rs2_q;
            default: ram_addrb = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + ADDR_W'(1);
                if (init_cnt_q == LAST_ADDR) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (accept) begin
                    rs1_d   = req_rs1;
                    rs2_d   = req_rs2;
                    state_d = ST_RD1;
                end
            end
            ST_RD1:  state_d = ST_RD2;
            ST_RD2: begin
                op1_d   = ram_dob;
                state_d = ST_CAP2;
            end
            ST_CAP2: begin
                op2_d   = ram_dob;
                state_d = ST_RSP;
            end
            ST_RSP: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RESET_STATE;
            init_cnt_q  <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            req_ready_q <= ~CLEAR_ON_RESET;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            req_ready_q <= (state_d == ST_IDLE);
        end
    end

    // Operand 1 is captured at the end of RD2 and operand 2 at the end of CAP2, so their forwarding windows differ.
    cpuregs_fwd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd1 (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (accept),
        .win_i     ((state_q == ST_RD1) | (state_q == ST_RD2)),
        .wen_i     (wr_acc),
        .addr_i    (rs1_q),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .fwd_vld_o (fwd1_vld),
        .fwd_dat_o (fwd1_dat)
    );

    cpuregs_fwd_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd2 (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (accept),
        .win_i     ((state_q == ST_RD1) | (state_q == ST_RD2) | (state_q == ST_CAP2)),
        .wen_i     (wr_acc),
        .addr_i    (rs2_q),
        .waddr_i   (waddr),
        .wdata_i   (wdata),
        .fwd_vld_o (fwd2_vld),
        .fwd_dat_o (fwd2_dat)
    );

    assign rsp_rdata1 = is_zero(rs1_q) ? '0 : (fwd1_vld ? fwd1_dat : op1_q);
    assign rsp_rdata2 = is_zero(rs2_q) ? '0 : (fwd2_vld ? fwd2_dat : op2_q);

endmodule

// File: tb/tb_cpuregs_port_sequencer.sv
// Scoreboard bench for cpuregs_port_sequencer: a read-first BRAM model, directed requests, and a decoupled response monitor.
`timescale 1ns/1ps
module tb_cpuregs_port_sequencer;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready;
    logic [ADDR_W-1:0] req_rs1, req_rs2;
    logic              rsp_valid, rsp_ready;
    logic [DATA_W-1:0] rsp_rdata1, rsp_rdata2;
    logic              wen;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              init_busy, ram_cea, ram_rsta, ram_rstb;
    logic [ADDR_W-1:0] ram_addra, ram_addrb;
    logic [DATA_W-1:0] ram_dia, ram_dob;

    always #5 clk = ~clk;

    cpuregs_port_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ZERO_REG(1'b1), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata1(rsp_rdata1), .rsp_rdata2(rsp_rdata2),
        .wen(wen), .waddr(waddr), .wdata(wdata),
        .init_busy(init_busy),
        .ram_cea(ram_cea), .ram_addra(ram_addra), .ram_dia(ram_dia),
        .ram_addrb(ram_addrb), .ram_dob(ram_dob),
        .ram_rsta(ram_rsta), .ram_rstb(ram_rstb)
    );

    // Read-first BRAM model, pre-filled with non-zero garbage so that the zero-fill is observable.
    logic [DATA_W-1:0] mem [64];
    logic              fill_garbage;
    logic              poke_vld;
    logic [ADDR_W-1:0] poke_addr;
    logic [DATA_W-1:0] poke_dat;

    always @(posedge clk) begin
        if (fill_garbage) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hBAD0_0000 | i;
        end else begin
            if (poke_vld) mem[poke_addr] <= poke_dat;
            if (ram_cea) mem[ram_addra] <= ram_dia;
        end
        ram_dob <= mem[ram_addrb];
    end

    typedef struct packed {
        logic [DATA_W-1:0] d1;
        logic [DATA_W-1:0] d2;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got 0x%08h/0x%08h, expected no response", rsp_rdata1, rsp_rdata2);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata1", rsp_rdata1, mon_e.d1);
                check("rsp_rdata2", rsp_rdata2, mon_e.d2);
            end
        end
    end

    task automatic wait_init(input string nm);
        int n = 0;
        @(negedge clk);
        while (init_busy && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(nm, n, 64);
        check({nm, "_req_ready"}, 32'(req_ready), 1);
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wen = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        check("wr_ram_cea", 32'(ram_cea), 32'(a != 0));
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                         input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                         input bit fwd, input logic [ADDR_W-1:0] fa, input logic [DATA_W-1:0] fd);
        int n = 0;
        int lat = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL req_ready_timeout: got 0, expected 1");
        end
        exp_q.push_back(exp_t'{d1: e1, d2: e2});
        req_valid = 1'b1; req_rs1 = a1; req_rs2 = a2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (fwd) begin
            wen = 1'b1; waddr = fa; wdata = fd;
        end
        do begin
            @(negedge clk);
            lat++;
            if (lat == 2) wen = 1'b0;
        end while (!rsp_valid && lat < 20);
        check("latency", lat, 4);
        @(posedge clk); #1;
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check(nm, exp_q.size(), 0);
    endtask

    initial begin
        int bad;
        int nz;
        rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b1;
        wen = 1'b0; waddr = '0; wdata = '0;
        fill_garbage = 1'b1; poke_vld = 1'b0; poke_addr = '0; poke_dat = '0;

        repeat (3) @(posedge clk);
        #1 fill_garbage = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rdata1", rsp_rdata1, 0);
        check("rst_rdata2", rsp_rdata2, 0);
        check("rst_init_busy", 32'(init_busy), 1);
        check("rst_ram_cea", 32'(ram_cea), 0);
        check("rst_ram_addrb", 32'(ram_addrb), 0);
        check("ram_rst_tied", 32'({ram_rsta, ram_rstb}), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        wait_init("init_len");
        nz = 0;
        for (int i = 0; i < 64; i++) if (mem[i] != 0) nz++;
        check("init_zero_fill", nz, 0);

        issue(6'd5, 6'd63, 32'h0, 32'h0, 1'b0, '0, '0);
        drain("drain_cleared");

        wr(6'd3, 32'hDEAD_BEEF);
        wr(6'd7, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;
        issue(6'd3, 6'd7, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, '0, '0);
        drain("drain_basic");

        wr(6'd0, 32'hFFFF_FFFF);
        poke_vld = 1'b1; poke_addr = 6'd0; poke_dat = 32'h5555_5555;
        @(posedge clk); #1;
        poke_vld = 1'b0;
        issue(6'd0, 6'd0, 32'h0, 32'h0, 1'b0, '0, '0);
        drain("drain_x0");

        wr(6'd9, 32'h0000_0011);
        @(posedge clk); #1;
        issue(6'd9, 6'd9, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1, 6'd9, 32'hA5A5_A5A5);
        drain("drain_fwd");

        rsp_ready = 1'b0;
        issue(6'd3, 6'd7, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, '0, '0);
        wr(6'd3, 32'hCAFE_F00D);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata1 !== 32'hDEAD_BEEF || rsp_rdata2 !== 32'h1234_5678) bad++;
        end
        check("hold_stable", bad, 0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        drain("drain_hold");
        issue(6'd3, 6'd3, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, '0, '0);
        drain("drain_after_hold");

        // Reset in RD2: this request must never produce a response.
        check("rd2rst_req_ready", 32'(req_ready), 1);
        req_valid = 1'b1; req_rs1 = 6'd4; req_rs2 = 6'd4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rd2_ram_addrb", 32'(ram_addrb), 4);
        rst = 1'b1; wen = 1'b1; waddr = 6'd5; wdata = 32'h7777_7777;
        @(negedge clk);
        check("rst_write_drop", 32'(ram_cea), 0);
        @(posedge clk); #1;
        rst = 1'b0; wen = 1'b0;
        check("rst_to_init", 32'(init_busy), 1);
        check("rst_rsp_drop", 32'(rsp_valid), 0);
        wait_init("reinit_len");
        check("reinit_x5", mem[5], 0);
        issue(6'd3, 6'd7, 32'h0, 32'h0, 1'b0, '0, '0);
        drain("drain_reinit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion within 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
